time_set_ctrl: RTL and testbench
================================

Name: time_set_ctrl

Overview:
- Button-driven controller that sequences setting of the hour/minute/second counter block.
- Pauses counting, edits a shadow copy of the time field by field, then issues a single-cycle load command.
- Sits between the debounced button front-end and the time counter. Also drives a blink flag for the display multiplexer.
- On inactivity timeout, aborts without loading.

Parameters:
- BLINK_HALF, 50_000_000: clk cycles per blink half-period (0.5 s at 100 MHz).
- TIMEOUT, 1_000_000_000: idle clk cycles in a set state before abort (10 s).
- REPEAT_DELAY, 50_000_000: hold cycles before auto-repeat starts (AUTO_REPEAT_EN only).
- REPEAT_RATE, 10_000_000: cycles between auto-repeat steps (AUTO_REPEAT_EN only).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset. Synchronous, active-low.
- mode_pulse  in  1  debounced one-cycle pulse, advances field.
- inc_pulse  in  1  debounced one-cycle pulse, increments current field.
- dec_pulse  in  1  debounced one-cycle pulse, decrements current field.
- inc_level  in  1  debounced held level of the inc button (used only with AUTO_REPEAT_EN).
- dec_level  in  1  debounced held level of the dec button (used only with AUTO_REPEAT_EN).
- cur_second  in  6  live seconds from the counter.
- cur_minute  in  6  live minutes from the counter.
- cur_hour  in  5  live hours from the counter.
- run_en  out  1  1 = counter may advance.
- load  out  1  one-cycle strobe: counter takes load_* and clears its sub-second count.
- load_second  out  6  shadow seconds.
- load_minute  out  6  shadow minutes.
- load_hour  out  5  shadow hours.
- edit_field  out  2  0 none, 1 hour, 2 minute, 3 second.
- blink  out  1  display blank phase for the field being edited.

Behaviour:
- Reset (reset_n low at a clk edge):
  - run_en=1, load=0, load_*=0, edit_field=0, blink=0.
  - state RUN; idle, blink and repeat counters 0.
  - Reset mid-edit aborts with no load.
- States: RUN, SET_HOUR, SET_MIN, SET_SEC, COMMIT. All outputs are registered.
- RUN:
  - run_en=1, blink=0, edit_field=0; inc/dec ignored.
  - mode_pulse: capture cur_* into load_* in that same edge, go SET_HOUR, run_en=0 from the next cycle.
- SET_HOUR / SET_MIN / SET_SEC:
  - edit_field = 1/2/3; run_en=0.
  - inc: field = (field==MAX) ? 0 : field+1. dec: field = (field==0) ? MAX : field-1.
  - MAX is 23 for hour, 59 for minute and second.
  - inc and dec in the same cycle: no change.
  - mode_pulse advances HOUR->MIN->SEC->COMMIT. If mode coincides with inc/dec, mode wins and the field is unchanged.
- COMMIT:
  - load=1 for exactly one cycle with the final shadow values; edit_field=0.
  - Next state RUN, with run_en=1 from that next cycle.
  - All button inputs ignored in COMMIT.
- Load latency: the mode press in SET_SEC appears as load=1 on the cycle after it; the counter sees the new time on the following edge.
- Timeout:
  - Idle counter clears on entering a set state and on any mode/inc/dec pulse (or repeat step); otherwise increments.
  - When it reaches TIMEOUT-1 in a set state: go RUN, load stays 0, run_en=1, and the counter resumes from the time it was paused at.
- Blink:
  - Counter runs only in set states and toggles blink every BLINK_HALF cycles.
  - Entering a set state or any inc/dec: blink=0 and the counter clears, so the field is shown solid while adjusting.
  - In RUN and COMMIT: blink=0.
- Shadow values are always kept in legal range. An out-of-range capture (e.g. cur_second=60 transient) is clamped to 0 at capture.

Optional Feature:
- Macro TIME_SET_AUTO_REPEAT_EN.
- Defined:
  - In a set state, a level held alone (inc_level xor dec_level) for REPEAT_DELAY cycles generates an internal step, then one step every REPEAT_RATE cycles until release.
  - Steps follow the same wrap rules and clear the idle and blink counters.
  - Release, or both levels high, resets the repeat counter.
- Undefined: inc_level/dec_level are ignored; no repeat logic is synthesised; ports remain.

Test Plan:
- Reset check: reset_n=0 two cycles mid-SET_MIN -> run_en=1, load=0, load_*=0, edit_field=0, blink=0 on the next cycle; no load ever issued.
- Full set: cur=13:45:30; mode, inc x11 (hour), mode, dec x46 (minute), mode, inc x30 (second), mode -> single load=1 with load_hour=0, load_minute=59, load_second=0; run_en=1 the cycle after.
- Wrap in both directions: hour=23 + inc -> 0; minute=0 + dec -> 59; second=59 + inc -> 0; inc&dec together -> unchanged.
- Timeout abort: TIMEOUT=100, BLINK_HALF=10; enter SET_HOUR, no input -> blink toggles every 10 cycles (first rise 10 cycles after entry); state returns to RUN 100 cycles after entry with load never asserted, run_en=1.
- Priority: mode and inc in the same cycle in SET_MIN -> state SET_SEC, minute unchanged; pulses during COMMIT -> ignored, exactly one load.
- Auto-repeat (macro defined, REPEAT_DELAY=20, REPEAT_RATE=5): hold inc_level 40 cycles in SET_SEC from 58 -> steps at cycles 20, 25, 30, 35, 40 -> second = 58+5 wrapped = 3. Macro undefined -> second stays 58.

Source files
------------

// File: rtl/time_set_if.sv
// time_set_if: button/counter-side signal bundle for time_set_ctrl
//   master: button front-end + time counter (drives pulses, levels, cur_*; receives run_en, load, load_*, edit_field, blink)
//   slave : time_set_ctrl
interface time_set_if;
    logic       mode_pulse;
    logic       inc_pulse;
    logic       dec_pulse;
    logic       inc_level;
    logic       dec_level;
    logic [5:0] cur_second;
    logic [5:0] cur_minute;
    logic [4:0] cur_hour;
    logic       run_en;
    logic       load;
    logic [5:0] load_second;
    logic [5:0] load_minute;
    logic [4:0] load_hour;
    logic [1:0] edit_field;
    logic       blink;
    modport master (
        output mode_pulse, inc_pulse, dec_pulse, inc_level, dec_level,
        output cur_second, cur_minute, cur_hour,
        input  run_en, load, load_second, load_minute, load_hour, edit_field, blink
    );
    modport slave (
        input  mode_pulse, inc_pulse, dec_pulse, inc_level, dec_level,
        input  cur_second, cur_minute, cur_hour,
        output run_en, load, load_second, load_minute, load_hour, edit_field, blink
    );
endinterface

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: pauses the time counter, edits a shadow copy field by field, then loads it
//   clk, reset_n : clock, synchronous active-low reset
//   bus (slave)  : mode/inc/dec pulses, inc/dec levels, cur_* live time in;
//                  run_en, load strobe, load_* shadow time, edit_field, blink out
//   Optional auto-repeat on held inc/dec levels: define TIME_SET_AUTO_REPEAT_EN
module time_set_ctrl #(
    parameter int unsigned BLINK_HALF   = 50_000_000,
    parameter int unsigned TIMEOUT      = 1_000_000_000,
    parameter int unsigned REPEAT_DELAY = 50_000_000,
    parameter int unsigned REPEAT_RATE  = 10_000_000
) (
    input logic        clk,
    input logic        reset_n,
    time_set_if.slave  bus
);
    typedef enum logic [2:0] {RUN, SET_HOUR, SET_MIN, SET_SEC, COMMIT} state_t;
    state_t      state_q, state_d;
    logic [4:0]  hour_q, hour_d;
    logic [5:0]  min_q, min_d, sec_q, sec_d;
    logic [31:0] idle_q, idle_d, blink_cnt_q, blink_cnt_d;
    logic        blink_q, blink_d, run_en_q, run_en_d, load_q, load_d;
    logic [1:0]  edit_field_q, edit_field_d;
    logic        in_set, up, down, blink_wrap;
    function automatic logic [5:0] step(input logic [5:0] v, input logic [5:0] max, input logic u, input logic d);
        return (u && !d) ? (v == max ? 6'd0 : v + 6'd1) : (d && !u) ? (v == 6'd0 ? max : v - 6'd1) : v;
    endfunction
    assign in_set = state_q inside {SET_HOUR, SET_MIN, SET_SEC};
`ifdef TIME_SET_AUTO_REPEAT_EN
    logic [31:0] rep_q, rep_d;
    logic        held, rep_step;
    // After each step the count is rewound by REPEAT_RATE so later steps come every REPEAT_RATE cycles
    // (assumes REPEAT_RATE <= REPEAT_DELAY).
    always_comb begin
        held     = in_set && (bus.inc_level ^ bus.dec_level);
        rep_step = held && (rep_q == REPEAT_DELAY - 1);
        rep_d    = !held ? '0 : rep_step ? REPEAT_DELAY - REPEAT_RATE : rep_q + 32'd1;
        up       = bus.inc_pulse | (rep_step & bus.inc_level);
        down     = bus.dec_pulse | (rep_step & bus.dec_level);
    end
    always_ff @(posedge clk) begin
        rep_q <= !reset_n ? '0 : rep_d;
    end
`else
    logic unused_levels;
    assign unused_levels = bus.inc_level ^ bus.dec_level;
    assign up            = bus.inc_pulse;
    assign down          = bus.dec_pulse;
`endif
    assign blink_wrap = (blink_cnt_q == BLINK_HALF - 1);
    always_comb begin
        state_d     = state_q;
        hour_d      = hour_q;
        min_d       = min_q;
        sec_d       = sec_q;
        idle_d      = '0;
        blink_cnt_d = '0;
        blink_d     = 1'b0;
        case (state_q)
            RUN: begin
                if (bus.mode_pulse) begin
                    state_d = SET_HOUR;
                    hour_d  = (bus.cur_hour > 5'd23) ? 5'd0 : bus.cur_hour;
                    min_d   = (bus.cur_minute > 6'd59) ? 6'd0 : bus.cur_minute;
                    sec_d   = (bus.cur_second > 6'd59) ? 6'd0 : bus.cur_second;
                end
            end
            COMMIT: state_d = RUN;
            default: begin
                if (bus.mode_pulse) begin
                    state_d = (state_q == SET_HOUR) ? SET_MIN : (state_q == SET_MIN) ? SET_SEC : COMMIT;
                end else if (up || down) begin
                    hour_d = (state_q == SET_HOUR) ? 5'(step({1'b0, hour_q}, 6'd23, up, down)) : hour_q;
                    min_d  = (state_q == SET_MIN) ? step(min_q, 6'd59, up, down) : min_q;
                    sec_d  = (state_q == SET_SEC) ? step(sec_q, 6'd59, up, down) : sec_q;
                end else if (idle_q == TIMEOUT - 1) begin
                    state_d = RUN;
                end else begin
                    idle_d      = idle_q + 32'd1;
                    blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + 32'd1;
                    blink_d     = blink_q ^ blink_wrap;
                end
            end
        endcase
        run_en_d     = (state_d == RUN);
        load_d       = (state_d == COMMIT);
        edit_field_d = (state_d == SET_HOUR) ? 2'd1 : (state_d == SET_MIN) ? 2'd2 : (state_d == SET_SEC) ? 2'd3 : 2'd0;
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= RUN;
            hour_q       <= '0;
            min_q        <= '0;
            sec_q        <= '0;
            idle_q       <= '0;
            blink_cnt_q  <= '0;
            blink_q      <= 1'b0;
            run_en_q     <= 1'b1;
            load_q       <= 1'b0;
            edit_field_q <= 2'd0;
        end else begin
            state_q      <= state_d;
            hour_q       <= hour_d;
            min_q        <= min_d;
            sec_q        <= sec_d;
            idle_q       <= idle_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_q      <= blink_d;
            run_en_q     <= run_en_d;
            load_q       <= load_d;
            edit_field_q <= edit_field_d;
        end
    end
    assign bus.run_en      = run_en_q;
    assign bus.load        = load_q;
    assign bus.load_hour   = hour_q;
    assign bus.load_minute = min_q;
    assign bus.load_second = sec_q;
    assign bus.edit_field  = edit_field_q;
    assign bus.blink       = blink_q;
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: scoreboard bench for time_set_ctrl (directed vectors, queued expectations)
module tb_time_set_ctrl;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    time_set_if bus();
    time_set_ctrl #(.BLINK_HALF(10), .TIMEOUT(100), .REPEAT_DELAY(20), .REPEAT_RATE(5)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );
    always #5 clk = ~clk;
    typedef struct {
        string      name;
        logic       run_en;
        logic       load;
        logic [1:0] ef;
        logic       blink;
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
    } chk_t;
    typedef struct {
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
    } ld_t;
    chk_t chk_q[$];
    ld_t  ld_q[$];
    chk_t c;
    ld_t  e;
    int   n_cmp = 0;
    int   n_bad = 0;
`ifdef TIME_SET_AUTO_REPEAT_EN
    localparam logic [5:0] SEC_MID = 6'd59;
    localparam logic [5:0] SEC_END = 6'd3;
`else
    localparam logic [5:0] SEC_MID = 6'd58;
    localparam logic [5:0] SEC_END = 6'd58;
`endif
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic pulse(input logic m, input logic i, input logic d);
        bus.mode_pulse = m;
        bus.inc_pulse  = i;
        bus.dec_pulse  = d;
        tick();
        bus.mode_pulse = 1'b0;
        bus.inc_pulse  = 1'b0;
        bus.dec_pulse  = 1'b0;
    endtask
    task automatic set_cur(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        bus.cur_hour   = h;
        bus.cur_minute = m;
        bus.cur_second = s;
    endtask
    task automatic push_chk(input string name, input logic r, input logic l, input logic [1:0] ef,
                            input logic b, input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        chk_t x;
        x.name = name; x.run_en = r; x.load = l; x.ef = ef; x.blink = b; x.h = h; x.m = m; x.s = s;
        chk_q.push_back(x);
    endtask
    task automatic push_ld(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        ld_t x;
        x.h = h; x.m = m; x.s = s;
        ld_q.push_back(x);
    endtask
    always @(negedge clk) begin
        if (bus.load === 1'b1) begin
            n_cmp++;
            if (ld_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_load: got load=1 %0d:%0d:%0d, required no load",
                         bus.load_hour, bus.load_minute, bus.load_second);
            end else begin
                e = ld_q.pop_front();
                if ({bus.load_hour, bus.load_minute, bus.load_second} !== {e.h, e.m, e.s}) begin
                    n_bad++;
                    $display("FAIL load_value: got %0d:%0d:%0d, required %0d:%0d:%0d",
                             bus.load_hour, bus.load_minute, bus.load_second, e.h, e.m, e.s);
                end
            end
        end
        if (chk_q.size() != 0) begin
            c = chk_q.pop_front();
            n_cmp++;
            if ({bus.run_en, bus.load, bus.edit_field, bus.blink, bus.load_hour, bus.load_minute, bus.load_second}
                !== {c.run_en, c.load, c.ef, c.blink, c.h, c.m, c.s}) begin
                n_bad++;
                $display("FAIL %s: got run_en=%0b load=%0b edit=%0d blink=%0b %0d:%0d:%0d, required run_en=%0b load=%0b edit=%0d blink=%0b %0d:%0d:%0d",
                         c.name, bus.run_en, bus.load, bus.edit_field, bus.blink, bus.load_hour, bus.load_minute,
                         bus.load_second, c.run_en, c.load, c.ef, c.blink, c.h, c.m, c.s);
            end
        end
    end
    initial begin
        bus.mode_pulse = 1'b0;
        bus.inc_pulse  = 1'b0;
        bus.dec_pulse  = 1'b0;
        bus.inc_level  = 1'b0;
        bus.dec_level  = 1'b0;
        set_cur(5'd0, 6'd0, 6'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        push_chk("reset", 1, 0, 2'd0, 0, 5'd0, 6'd0, 6'd0);
        // full set 13:45:30 -> 00:59:00
        set_cur(5'd13, 6'd45, 6'd30);
        pulse(1, 0, 0);
        push_chk("enter_hour", 0, 0, 2'd1, 0, 5'd13, 6'd45, 6'd30);
        repeat (11) pulse(0, 1, 0);
        push_chk("hour_inc11", 0, 0, 2'd1, 0, 5'd0, 6'd45, 6'd30);
        pulse(1, 0, 0);
        push_chk("enter_min", 0, 0, 2'd2, 0, 5'd0, 6'd45, 6'd30);
        repeat (46) pulse(0, 0, 1);
        push_chk("min_dec46", 0, 0, 2'd2, 0, 5'd0, 6'd59, 6'd30);
        pulse(1, 0, 0);
        repeat (30) pulse(0, 1, 0);
        push_chk("sec_inc30", 0, 0, 2'd3, 0, 5'd0, 6'd59, 6'd0);
        push_ld(5'd0, 6'd59, 6'd0);
        pulse(1, 0, 0);
        push_chk("commit", 0, 1, 2'd0, 0, 5'd0, 6'd59, 6'd0);
        tick();
        push_chk("run_after_commit", 1, 0, 2'd0, 0, 5'd0, 6'd59, 6'd0);
        // wraps and priority
        set_cur(5'd23, 6'd0, 6'd59);
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        push_chk("hour_wrap", 0, 0, 2'd1, 0, 5'd0, 6'd0, 6'd59);
        pulse(1, 0, 0);
        pulse(0, 0, 1);
        push_chk("min_wrap", 0, 0, 2'd2, 0, 5'd0, 6'd59, 6'd59);
        pulse(0, 1, 1);
        push_chk("inc_dec_same", 0, 0, 2'd2, 0, 5'd0, 6'd59, 6'd59);
        pulse(1, 1, 0);
        push_chk("mode_wins", 0, 0, 2'd3, 0, 5'd0, 6'd59, 6'd59);
        pulse(0, 1, 0);
        push_chk("sec_wrap", 0, 0, 2'd3, 0, 5'd0, 6'd59, 6'd0);
        push_ld(5'd0, 6'd59, 6'd0);
        pulse(1, 0, 0);
        pulse(1, 1, 1);
        push_chk("commit_ignores", 1, 0, 2'd0, 0, 5'd0, 6'd59, 6'd0);
        tick();
        push_chk("still_run", 1, 0, 2'd0, 0, 5'd0, 6'd59, 6'd0);
        // clamp on capture, blink and timeout
        set_cur(5'd25, 6'd60, 6'd63);
        pulse(1, 0, 0);
        push_chk("clamp", 0, 0, 2'd1, 0, 5'd0, 6'd0, 6'd0);
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (k == 9)   push_chk("blink_low9", 0, 0, 2'd1, 0, 5'd0, 6'd0, 6'd0);
            if (k == 10)  push_chk("blink_rise10", 0, 0, 2'd1, 1, 5'd0, 6'd0, 6'd0);
            if (k == 19)  push_chk("blink_high19", 0, 0, 2'd1, 1, 5'd0, 6'd0, 6'd0);
            if (k == 20)  push_chk("blink_fall20", 0, 0, 2'd1, 0, 5'd0, 6'd0, 6'd0);
            if (k == 99)  push_chk("pre_timeout", 0, 0, 2'd1, 1, 5'd0, 6'd0, 6'd0);
            if (k == 100) push_chk("timeout", 1, 0, 2'd0, 0, 5'd0, 6'd0, 6'd0);
        end
        // reset mid-edit
        set_cur(5'd10, 6'd20, 6'd30);
        pulse(1, 0, 0);
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        push_chk("min_edit", 0, 0, 2'd2, 0, 5'd10, 6'd21, 6'd30);
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        push_chk("reset_mid_edit", 1, 0, 2'd0, 0, 5'd0, 6'd0, 6'd0);
        repeat (5) tick();
        push_chk("idle_after_reset", 1, 0, 2'd0, 0, 5'd0, 6'd0, 6'd0);
        // held inc level in SET_SEC
        set_cur(5'd0, 6'd0, 6'd58);
        repeat (3) pulse(1, 0, 0);
        push_chk("enter_sec", 0, 0, 2'd3, 0, 5'd0, 6'd0, 6'd58);
        bus.inc_level = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 20) push_chk("repeat_first", 0, 0, 2'd3, 0, 5'd0, 6'd0, SEC_MID);
            if (k == 40) push_chk("repeat_end", 0, 0, 2'd3, 0, 5'd0, 6'd0, SEC_END);
        end
        bus.inc_level = 1'b0;
        push_ld(5'd0, 6'd0, SEC_END);
        pulse(1, 0, 0);
        push_chk("repeat_commit", 0, 1, 2'd0, 0, 5'd0, 6'd0, SEC_END);
        repeat (3) tick();
        n_cmp++;
        if (ld_q.size() != 0 || chk_q.size() != 0) begin
            n_bad++;
            $display("FAIL queues_drained: got %0d loads and %0d checks pending, required 0 and 0",
                     ld_q.size(), chk_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
